// File: rtl/bp_be_fp_wb_arbiter.sv
// bp_be_fp_wb_arbiter: shares the FP regfile write port between the FMA pipe and the aux pipe.
// Aux results wait in a credit-guarded FIFO while FMA owns the port; written-back fflags are accrued.
module bp_be_fp_wb_arbiter #(
    parameter int dpath_width_p    = 66,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        aux_issue_i,
    output logic                        aux_ready_o,
    input  logic                        aux_v_i,
    input  logic [dpath_width_p-1:0]    aux_data_i,
    input  logic [4:0]                  aux_fflags_i,
    input  logic [reg_addr_width_p-1:0] aux_rd_i,
    input  logic                        fma_v_i,
    input  logic [dpath_width_p-1:0]    fma_data_i,
    input  logic [4:0]                  fma_fflags_i,
    input  logic [reg_addr_width_p-1:0] fma_rd_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_addr_o,
    output logic [dpath_width_p-1:0]    wb_data_o,
    input  logic                        fflags_clr_i,
    output logic [4:0]                  fflags_o
);
    localparam int pw = $clog2(els_p);
    localparam int cw = $clog2(els_p + 1);
    localparam int ew = dpath_width_p + 5 + reg_addr_width_p;

    logic [ew-1:0]               mem_q [els_p];
    logic [pw-1:0]               rd_q, rd_d, wr_q, wr_d;
    logic                        full_q, full_d;
    logic [cw-1:0]               cnt_q, cnt_d;
    logic [4:0]                  fflags_q, fflags_d;
    logic                        wb_v_q;
    logic [reg_addr_width_p-1:0] wb_addr_q;
    logic [dpath_width_p-1:0]    wb_data_q;
    logic                        empty, enq, deq, bypass, sel_v;
    logic [ew-1:0]               aux_e, sel_e;

    // Priority: FMA (cannot stall), then queued aux in order, then aux bypass.
    always_comb begin
        empty    = (rd_q == wr_q) && !full_q;
        aux_e    = {aux_data_i, aux_fflags_i, aux_rd_i};
        deq      = !fma_v_i && !empty;
        enq      = aux_v_i && (fma_v_i || !empty);
        bypass   = aux_v_i && !fma_v_i && empty;
        sel_v    = fma_v_i || !empty || aux_v_i;
        sel_e    = fma_v_i ? {fma_data_i, fma_fflags_i, fma_rd_i} : deq ? mem_q[rd_q] : aux_e;
        rd_d     = deq ? rd_q + pw'(1) : rd_q;
        wr_d     = enq ? wr_q + pw'(1) : wr_q;
        full_d   = (enq && !deq) ? (wr_d == rd_q) : (deq && !enq) ? 1'b0 : full_q;
        cnt_d    = cnt_q + cw'(deq || bypass) - cw'(aux_issue_i);
        fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (sel_v ? sel_e[reg_addr_width_p +: 5] : 5'b0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q      <= '0;
            wr_q      <= '0;
            full_q    <= 1'b0;
            cnt_q     <= cw'(els_p);
            fflags_q  <= '0;
            wb_v_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            full_q   <= full_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
            wb_v_q   <= sel_v;
            if (sel_v) begin
                wb_addr_q <= sel_e[reg_addr_width_p-1:0];
                wb_data_q <= sel_e[ew-1 -: dpath_width_p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_q] <= aux_e;
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(aux_issue_i && cnt_q == '0));
            assert (cnt_q <= cw'(els_p));
            assert (!(enq && full_q && !deq));
        end
    end

    assign aux_ready_o = cnt_q != '0;
    assign wb_v_o      = wb_v_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign fflags_o    = fflags_q;
endmodule

// File: tb/tb_bp_be_fp_wb_arbiter.sv
// tb_bp_be_fp_wb_arbiter: directed scenarios for the FP writeback arbiter.
module tb_bp_be_fp_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        aux_issue_i, aux_v_i, fma_v_i, fflags_clr_i;
    logic [65:0] aux_data_i, fma_data_i;
    logic [4:0]  aux_fflags_i, fma_fflags_i, aux_rd_i, fma_rd_i;
    logic        aux_ready_o, wb_v_o;
    logic [4:0]  wb_addr_o, fflags_o;
    logic [65:0] wb_data_o;
    int pass_n = 0;
    int tot_n = 0;

    bp_be_fp_wb_arbiter dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .aux_issue_i(aux_issue_i), .aux_ready_o(aux_ready_o),
        .aux_v_i(aux_v_i), .aux_data_i(aux_data_i), .aux_fflags_i(aux_fflags_i), .aux_rd_i(aux_rd_i),
        .fma_v_i(fma_v_i), .fma_data_i(fma_data_i), .fma_fflags_i(fma_fflags_i), .fma_rd_i(fma_rd_i),
        .wb_v_o(wb_v_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [65:0] dat(input logic [4:0] r, input logic f);
        return {f, 60'hA5A5_A5A5_A5A5_A5A, r};
    endfunction

    task automatic idle();
        aux_issue_i = 0; aux_v_i = 0; fma_v_i = 0; fflags_clr_i = 0;
        aux_data_i = '0; fma_data_i = '0; aux_fflags_i = '0; fma_fflags_i = '0;
        aux_rd_i = '0; fma_rd_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic aux(input logic [4:0] r, input logic [4:0] f);
        aux_v_i = 1; aux_rd_i = r; aux_data_i = dat(r, 1'b0); aux_fflags_i = f;
    endtask

    task automatic fma(input logic [4:0] r, input logic [4:0] f);
        fma_v_i = 1; fma_rd_i = r; fma_data_i = dat(r, 1'b1); fma_fflags_i = f;
    endtask

    task automatic test_reset();
        idle();
        #2 reset_n_i = 0;
        #1;
        tot_n++; if (wb_v_o !== 1'b0) $display("FAIL rst_wb_v got %b want 0", wb_v_o); else pass_n++;
        tot_n++; if (wb_addr_o !== 5'd0 || wb_data_o !== 66'd0) $display("FAIL rst_wb_ad got %0d/%h want 0/0", wb_addr_o, wb_data_o); else pass_n++;
        tot_n++; if (fflags_o !== 5'b0) $display("FAIL rst_fflags got %b want 00000", fflags_o); else pass_n++;
        tot_n++; if (aux_ready_o !== 1'b1) $display("FAIL rst_ready got %b want 1", aux_ready_o); else pass_n++;
        #9 reset_n_i = 1;
    endtask

    task automatic test_lone_aux();
        aux_issue_i = 1;
        tick();
        tot_n++; if (dut.cnt_q !== 3'd3) $display("FAIL lone_cnt_issue got %0d want 3", dut.cnt_q); else pass_n++;
        aux(5'd3, 5'b00001);
        tick();
        tot_n++; if (wb_v_o !== 1'b1) $display("FAIL lone_v got %b want 1", wb_v_o); else pass_n++;
        tot_n++; if (wb_addr_o !== 5'd3) $display("FAIL lone_addr got %0d want 3", wb_addr_o); else pass_n++;
        tot_n++; if (wb_data_o !== dat(5'd3, 1'b0)) $display("FAIL lone_data got %h want %h", wb_data_o, dat(5'd3, 1'b0)); else pass_n++;
        tot_n++; if (fflags_o !== 5'b00001) $display("FAIL lone_fflags got %b want 00001", fflags_o); else pass_n++;
        tot_n++; if (dut.cnt_q !== 3'd4) $display("FAIL lone_cnt got %0d want 4", dut.cnt_q); else pass_n++;
        tick();
        tot_n++; if (wb_v_o !== 1'b0 || wb_addr_o !== 5'd3) $display("FAIL lone_hold got %b/%0d want 0/3", wb_v_o, wb_addr_o); else pass_n++;
    endtask

    task automatic test_collision();
        aux_issue_i = 1;
        tick();
        fma(5'd7, 5'b0);
        aux(5'd9, 5'b0);
        tick();
        tot_n++; if (wb_v_o !== 1'b1 || wb_addr_o !== 5'd7) $display("FAIL coll_fma got %b/%0d want 1/7", wb_v_o, wb_addr_o); else pass_n++;
        tot_n++; if (wb_data_o !== dat(5'd7, 1'b1)) $display("FAIL coll_fma_data got %h want %h", wb_data_o, dat(5'd7, 1'b1)); else pass_n++;
        tick();
        tot_n++; if (wb_v_o !== 1'b1 || wb_addr_o !== 5'd9) $display("FAIL coll_aux got %b/%0d want 1/9", wb_v_o, wb_addr_o); else pass_n++;
        tot_n++; if (wb_data_o !== dat(5'd9, 1'b0)) $display("FAIL coll_aux_data got %h want %h", wb_data_o, dat(5'd9, 1'b0)); else pass_n++;
        tot_n++; if (dut.empty !== 1'b1 || dut.cnt_q !== 3'd4) $display("FAIL coll_drain got empty %b cnt %0d want 1/4", dut.empty, dut.cnt_q); else pass_n++;
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) begin
            aux_issue_i = 1;
            tick();
        end
        tot_n++; if (aux_ready_o !== 1'b0) $display("FAIL burst_ready got %b want 0", aux_ready_o); else pass_n++;
        for (int i = 0; i < 6; i++) begin
            fma(5'(20 + i), i == 0 ? 5'b00100 : 5'b0);
            if (i < 4) aux(5'(11 + i), i == 1 ? 5'b00010 : 5'b0);
            tick();
            tot_n++; if (wb_v_o !== 1'b1 || wb_addr_o !== 5'(20 + i)) $display("FAIL burst_fma%0d got %b/%0d want 1/%0d", i, wb_v_o, wb_addr_o, 20 + i); else pass_n++;
        end
        tot_n++; if (aux_ready_o !== 1'b0) $display("FAIL burst_ready_hold got %b want 0", aux_ready_o); else pass_n++;
        for (int k = 0; k < 4; k++) begin
            tick();
            tot_n++; if (wb_v_o !== 1'b1 || wb_addr_o !== 5'(11 + k)) $display("FAIL burst_aux%0d got %b/%0d want 1/%0d", k, wb_v_o, wb_addr_o, 11 + k); else pass_n++;
            tot_n++; if (wb_data_o !== dat(5'(11 + k), 1'b0)) $display("FAIL burst_aux_data%0d got %h want %h", k, wb_data_o, dat(5'(11 + k), 1'b0)); else pass_n++;
            if (k == 0) begin
                tot_n++; if (aux_ready_o !== 1'b1) $display("FAIL burst_ready_ret got %b want 1", aux_ready_o); else pass_n++;
            end
        end
        tot_n++; if (dut.cnt_q !== 3'd4 || dut.empty !== 1'b1) $display("FAIL burst_end got cnt %0d empty %b want 4/1", dut.cnt_q, dut.empty); else pass_n++;
        tot_n++; if (fflags_o !== 5'b00111) $display("FAIL burst_fflags got %b want 00111", fflags_o); else pass_n++;
        tick();
        tot_n++; if (wb_v_o !== 1'b0) $display("FAIL burst_idle got %b want 0", wb_v_o); else pass_n++;
    endtask

    task automatic test_credit();
        for (int i = 0; i < 4; i++) begin
            aux_issue_i = 1;
            tick();
        end
        tot_n++; if (aux_ready_o !== 1'b0) $display("FAIL credit_zero got %b want 0", aux_ready_o); else pass_n++;
        aux(5'd1, 5'b0);
        tick();
        tot_n++; if (aux_ready_o !== 1'b1 || dut.cnt_q !== 3'd1) $display("FAIL credit_ret got %b/%0d want 1/1", aux_ready_o, dut.cnt_q); else pass_n++;
        aux_issue_i = 1;
        aux(5'd2, 5'b0);
        tick();
        tot_n++; if (dut.cnt_q !== 3'd1 || wb_addr_o !== 5'd2) $display("FAIL credit_both got cnt %0d addr %0d want 1/2", dut.cnt_q, wb_addr_o); else pass_n++;
        for (int i = 0; i < 3; i++) begin
            aux(5'd0, 5'b0);
            tick();
        end
        tot_n++; if (dut.cnt_q !== 3'd4 || wb_addr_o !== 5'd0) $display("FAIL credit_full got cnt %0d addr %0d want 4/0", dut.cnt_q, wb_addr_o); else pass_n++;
    endtask

    task automatic test_flags();
        fflags_clr_i = 1;
        tick();
        tot_n++; if (fflags_o !== 5'b00000) $display("FAIL flags_clr got %b want 00000", fflags_o); else pass_n++;
        aux_issue_i = 1;
        tick();
        aux(5'd5, 5'b00001);
        tick();
        tot_n++; if (fflags_o !== 5'b00001) $display("FAIL flags_nx got %b want 00001", fflags_o); else pass_n++;
        aux_issue_i = 1;
        tick();
        aux(5'd6, 5'b01000);
        fflags_clr_i = 1;
        tick();
        tot_n++; if (fflags_o !== 5'b01000) $display("FAIL flags_clr_set got %b want 01000", fflags_o); else pass_n++;
        fflags_clr_i = 1;
        tick();
        tot_n++; if (fflags_o !== 5'b00000) $display("FAIL flags_clr_alone got %b want 00000", fflags_o); else pass_n++;
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin
            aux_issue_i = 1;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            fma(5'(24 + i), 5'b10000);
            aux(5'(16 + i), 5'b0);
            tick();
        end
        tot_n++; if (dut.empty !== 1'b0 || fflags_o !== 5'b10000) $display("FAIL mid_pre got empty %b fflags %b want 0/10000", dut.empty, fflags_o); else pass_n++;
        #2 reset_n_i = 0;
        #1;
        tot_n++; if (wb_v_o !== 1'b0 || wb_addr_o !== 5'd0 || wb_data_o !== 66'd0) $display("FAIL mid_rst_wb got %b/%0d/%h want 0/0/0", wb_v_o, wb_addr_o, wb_data_o); else pass_n++;
        tot_n++; if (fflags_o !== 5'b0) $display("FAIL mid_rst_fflags got %b want 00000", fflags_o); else pass_n++;
        tot_n++; if (dut.cnt_q !== 3'd4 || aux_ready_o !== 1'b1) $display("FAIL mid_rst_cnt got %0d/%b want 4/1", dut.cnt_q, aux_ready_o); else pass_n++;
        #2 reset_n_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tot_n++; if (wb_v_o !== 1'b0) $display("FAIL mid_stale%0d got %b want 0", i, wb_v_o); else pass_n++;
        end
    endtask

    initial begin
        test_reset();
        test_lone_aux();
        test_collision();
        test_burst();
        test_credit();
        test_flags();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
